rr_one_hot_arbiter: RTL and testbench

//  N-way round-robin arbiter with one-hot grant and a valid/ready handshake toward the shared resource.

---
 rtl/rr_one_hot_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rr_one_hot_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_one_hot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_one_hot_arbiter
//   N-way round-robin arbiter with a one-hot grant and a valid/ready handshake
//   toward the shared resource. Priority rotates to just above the last
//   accepted grant. With LOCK_EN=1, a grant that is offered but not accepted
//   is held until accepted. If the holder drops its request first, arbitration
//   resumes in that same cycle.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active-low
//   req_i        in   N_REQ  request vector, bit i = requester i
//   flush_i      in   1      synchronous: restore reset priority, drop any lock
//   grant_o      out  N_REQ  one-hot grant (zero when nothing requests)
//   grant_id_o   out  ID_W   binary index of grant_o (0 when grant_o == 0)
//   grant_vld_o  out  1      |grant_o
//   grant_rdy_i  in   1      downstream accepts; handshake = grant_vld_o & grant_rdy_i
//
// Grant outputs are combinational (zero latency) from req_i and state.
// grant_rdy_i only affects next state and has no path to any output.
// -----------------------------------------------------------------------------
module rr_one_hot_arbiter #(
    parameter int unsigned N_REQ   = 8,
    parameter bit          LOCK_EN = 1'b1,
    localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             flush_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_id_o,
    output logic             grant_vld_o,
    input  logic             grant_rdy_i
);

    // Last grant parked on the top index, so index 0 wins first after reset.
    localparam logic [N_REQ-1:0] LAST_RST = N_REQ'(1) << (N_REQ - 1);

    logic [N_REQ-1:0] last_q;
    logic [N_REQ-1:0] last_d;
    logic [N_REQ-1:0] mask_c;
    logic [N_REQ-1:0] masked_c;
    logic [N_REQ-1:0] arb_gnt_c;
    logic             lock_q;
    logic [N_REQ-1:0] lock_gnt_q;
    logic             hold_c;
    logic             hs_c;

    // Round-robin pick: lowest request strictly above the last grant, else lowest overall.
    always_comb begin
        mask_c    = ~((last_q << 1) - N_REQ'(1));
        masked_c  = req_i & mask_c;
        arb_gnt_c = (masked_c != '0) ? (masked_c & (~masked_c + N_REQ'(1)))
                                     : (req_i & (~req_i + N_REQ'(1)));
    end

    // A lock only counts while its holder still requests.
    assign hold_c      = lock_q & (|(req_i & lock_gnt_q));
    assign grant_o     = hold_c ? lock_gnt_q : arb_gnt_c;
    assign grant_vld_o = |grant_o;
    assign hs_c        = grant_vld_o & grant_rdy_i;

    // One-hot to binary.
    always_comb begin
        grant_id_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_o[i]) begin
                grant_id_o = grant_id_o | ID_W'(i);
            end
        end
    end

    // Rotation pointer: advances on handshake, flush restores reset priority.
    always_comb begin
        last_d = last_q;
        if (flush_i) begin
            last_d = LAST_RST;
        end else if (hs_c) begin
            last_d = grant_o;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= LAST_RST;
        end else begin
            last_q <= last_d;
        end
    end

    if (LOCK_EN) begin : g_lock
        typedef enum logic {
            ST_ARB    = 1'b0,
            ST_LOCKED = 1'b1
        } state_e;

        state_e           state_q;
        state_e           state_d;
        logic [N_REQ-1:0] lock_gnt_d;

        // Lock state register.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q    <= ST_ARB;
                lock_gnt_q <= '0;
            end else begin
                state_q    <= state_d;
                lock_gnt_q <= lock_gnt_d;
            end
        end

        // Lock next-state: a stalled offer locks, handshake or holder drop releases.
        always_comb begin
            state_d    = state_q;
            lock_gnt_d = lock_gnt_q;
            if (flush_i) begin
                state_d    = ST_ARB;
                lock_gnt_d = '0;
            end else begin
                case (state_q)
                    ST_ARB: begin
                        if (grant_vld_o && !grant_rdy_i) begin
                            state_d    = ST_LOCKED;
                            lock_gnt_d = grant_o;
                        end
                    end
                    ST_LOCKED: begin
                        if (hold_c) begin
                            if (grant_rdy_i) begin
                                state_d = ST_ARB;
                            end
                        end else if (grant_vld_o && !grant_rdy_i) begin
                            // Holder left; the fresh winner stalled, so lock onto it.
                            lock_gnt_d = grant_o;
                        end else begin
                            state_d = ST_ARB;
                        end
                    end
                    default: begin
                        state_d = ST_ARB;
                    end
                endcase
            end
        end

        assign lock_q = (state_q == ST_LOCKED);
    end else begin : g_nolock
        assign lock_q     = 1'b0;
        assign lock_gnt_q = '0;
    end

    // Grant sanity and lock hold: a held grant matches the captured grant.
    always @(posedge clk) begin
        if (rst) begin
            assert ($onehot0(grant_o));
            assert ((grant_o & ~req_i) == '0);
            if (lock_q && ((req_i & lock_gnt_q) != '0)) begin
                assert (grant_o == lock_gnt_q);
            end
        end
    end

endmodule

// File: tb/tb_rr_one_hot_arbiter.sv
module tb_rr_one_hot_arbiter;

    localparam int unsigned N   = 8;
    localparam int unsigned IDW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic           flush;
    logic           rdy;

    logic [N-1:0]   g_lk, g_nl;
    logic [IDW-1:0] id_lk, id_nl;
    logic           vld_lk, vld_nl;
    logic [0:0]     g_one;
    logic [0:0]     id_one;
    logic           vld_one;

    int checks = 0;
    int errors = 0;

    // Reference state per variant: 0 = locking instance, 1 = non-locking instance.
    int             m_last[2];
    bit             m_locked[2];
    int             m_lock_idx[2];
    int             exp_p[2];
    logic [N-1:0]   exp_g[2];
    logic [IDW-1:0] exp_id[2];

    always #5 clk = ~clk;

    rr_one_hot_arbiter #(.N_REQ(N), .LOCK_EN(1'b1)) dut_lk (
        .clk(clk), .rst(rst), .req_i(req), .flush_i(flush),
        .grant_o(g_lk), .grant_id_o(id_lk), .grant_vld_o(vld_lk), .grant_rdy_i(rdy)
    );

    rr_one_hot_arbiter #(.N_REQ(N), .LOCK_EN(1'b0)) dut_nl (
        .clk(clk), .rst(rst), .req_i(req), .flush_i(flush),
        .grant_o(g_nl), .grant_id_o(id_nl), .grant_vld_o(vld_nl), .grant_rdy_i(rdy)
    );

    rr_one_hot_arbiter #(.N_REQ(1), .LOCK_EN(1'b1)) dut_one (
        .clk(clk), .rst(rst), .req_i(req[0:0]), .flush_i(flush),
        .grant_o(g_one), .grant_id_o(id_one), .grant_vld_o(vld_one), .grant_rdy_i(rdy)
    );

    // Circular search starting just after the last winner; a live lock overrides it.
    function automatic int model_pick(input int v, input logic [N-1:0] r);
        if (m_locked[v] && r[m_lock_idx[v]]) return m_lock_idx[v];
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last[v] + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_last[v]     = N - 1;
            m_locked[v]   = 1'b0;
            m_lock_idx[v] = 0;
        end
    endtask

    // Drive inputs (called just after a falling edge) and compute expected outputs.
    task automatic apply(input logic [N-1:0] r, input logic y, input logic f);
        req   = r;
        rdy   = y;
        flush = f;
        #1;
        for (int v = 0; v < 2; v++) begin
            exp_p[v]  = model_pick(v, r);
            exp_g[v]  = (exp_p[v] < 0) ? '0 : (N'(1) << exp_p[v]);
            exp_id[v] = (exp_p[v] < 0) ? '0 : IDW'(exp_p[v]);
        end
    endtask

    // Advance one clock and update the reference state.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int v = 0; v < 2; v++) begin
                if (flush) begin
                    m_last[v]   = N - 1;
                    m_locked[v] = 1'b0;
                end else begin
                    if (exp_p[v] >= 0 && rdy) m_last[v] = exp_p[v];
                    m_locked[v]   = (v == 0) && (exp_p[v] >= 0) && !rdy;
                    m_lock_idx[v] = exp_p[v];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; rdy = 1'b0; flush = 1'b0;
        model_reset();
        #2;
        checks++; if (g_lk !== '0)    begin errors++; $display("FAIL reset_grant got=%h exp=00", g_lk); end
        checks++; if (id_lk !== '0)   begin errors++; $display("FAIL reset_id got=%0d exp=0", id_lk); end
        checks++; if (vld_lk !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", vld_lk); end
        checks++; if (g_nl !== '0)    begin errors++; $display("FAIL reset_grant_nl got=%h exp=00", g_nl); end
        req = 8'hFF;
        #1;
        checks++; if (g_lk !== 8'h01) begin errors++; $display("FAIL reset_prio got=%h exp=01", g_lk); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_rotation();
        for (int i = 0; i < 9; i++) begin
            logic [N-1:0] want;
            want = N'(1) << (i % 8);
            apply(8'hFF, 1'b1, 1'b0);
            checks++; if (g_lk !== want) begin errors++; $display("FAIL rot_grant cyc=%0d got=%h exp=%h", i, g_lk, want); end
            checks++; if (id_lk !== IDW'(i % 8)) begin errors++; $display("FAIL rot_id cyc=%0d got=%0d exp=%0d", i, id_lk, i % 8); end
            checks++; if (g_nl !== want) begin errors++; $display("FAIL rot_grant_nl cyc=%0d got=%h exp=%h", i, g_nl, want); end
            tick();
        end
    endtask

    task automatic test_alternate();
        logic [N-1:0] want[4];
        want = '{8'h01, 8'h80, 8'h01, 8'h80};
        apply(8'h00, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(8'h81, 1'b1, 1'b0);
            checks++; if (g_lk !== want[i]) begin errors++; $display("FAIL alt_grant cyc=%0d got=%h exp=%h", i, g_lk, want[i]); end
            tick();
        end
    endtask

    task automatic test_lock_hold();
        logic [N-1:0] r_seq[5];
        logic         y_seq[5];
        logic [N-1:0] want[5];
        logic [N-1:0] want_nl[5];
        r_seq   = '{8'h06, 8'h07, 8'h07, 8'h07, 8'h07};
        y_seq   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        want    = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h04};
        want_nl = '{8'h02, 8'h01, 8'h01, 8'h01, 8'h02};
        for (int i = 0; i < 5; i++) begin
            apply(r_seq[i], y_seq[i], 1'b0);
            checks++; if (g_lk !== want[i]) begin errors++; $display("FAIL lock_grant cyc=%0d got=%h exp=%h", i, g_lk, want[i]); end
            checks++; if (g_nl !== want_nl[i]) begin errors++; $display("FAIL lock_grant_nl cyc=%0d got=%h exp=%h", i, g_nl, want_nl[i]); end
            tick();
        end
    endtask

    task automatic test_holder_drop();
        apply(8'h00, 1'b0, 1'b1);
        tick();
        apply(8'h02, 1'b0, 1'b0);
        checks++; if (g_lk !== 8'h02) begin errors++; $display("FAIL drop_setup got=%h exp=02", g_lk); end
        tick();
        apply(8'h04, 1'b0, 1'b0);
        checks++; if (g_lk !== 8'h04) begin errors++; $display("FAIL drop_same_cycle got=%h exp=04", g_lk); end
        tick();
        apply(8'h0E, 1'b0, 1'b0);
        checks++; if (g_lk !== 8'h04) begin errors++; $display("FAIL drop_relock got=%h exp=04", g_lk); end
        checks++; if (id_lk !== 3'd2) begin errors++; $display("FAIL drop_relock_id got=%0d exp=2", id_lk); end
        tick();
        apply(8'h0E, 1'b1, 1'b0);
        checks++; if (g_lk !== 8'h04) begin errors++; $display("FAIL drop_accept got=%h exp=04", g_lk); end
        tick();
    endtask

    task automatic test_flush();
        apply(8'h00, 1'b0, 1'b1);
        tick();
        apply(8'h10, 1'b1, 1'b0);
        checks++; if (g_lk !== 8'h10) begin errors++; $display("FAIL flush_setup got=%h exp=10", g_lk); end
        tick();
        apply(8'hFF, 1'b1, 1'b1);
        checks++; if (g_lk !== 8'h20) begin errors++; $display("FAIL flush_cycle_out got=%h exp=20", g_lk); end
        tick();
        apply(8'hFF, 1'b1, 1'b0);
        checks++; if (g_lk !== 8'h01) begin errors++; $display("FAIL flush_after got=%h exp=01", g_lk); end
        checks++; if (g_nl !== 8'h01) begin errors++; $display("FAIL flush_after_nl got=%h exp=01", g_nl); end
        tick();
    endtask

    task automatic test_async_reset();
        apply(8'h00, 1'b0, 1'b1);
        tick();
        apply(8'h20, 1'b0, 1'b0);
        tick();
        apply(8'hFF, 1'b0, 1'b0);
        checks++; if (g_lk !== 8'h20) begin errors++; $display("FAIL areset_locked got=%h exp=20", g_lk); end
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (g_lk !== 8'h01) begin errors++; $display("FAIL areset_immediate got=%h exp=01", g_lk); end
        checks++; if (id_lk !== 3'd0) begin errors++; $display("FAIL areset_id got=%0d exp=0", id_lk); end
        @(negedge clk);
        rst = 1'b1;
        apply(8'hFF, 1'b0, 1'b0);
        checks++; if (g_lk !== 8'h01) begin errors++; $display("FAIL areset_release got=%h exp=01", g_lk); end
        tick();
    endtask

    task automatic test_nolock();
        apply(8'h00, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(8'h06, 1'b0, 1'b0);
            checks++; if (g_nl !== 8'h02) begin errors++; $display("FAIL nolock_grant cyc=%0d got=%h exp=02", i, g_nl); end
            tick();
        end
        apply(8'h07, 1'b0, 1'b0);
        checks++; if (g_nl !== 8'h01) begin errors++; $display("FAIL nolock_rearb got=%h exp=01", g_nl); end
        checks++; if (g_lk !== 8'h02) begin errors++; $display("FAIL nolock_lk_hold got=%h exp=02", g_lk); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] r;
            logic         y;
            logic         f;
            r = N'($urandom) & N'($urandom | $urandom);
            y = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 24) == 0);
            apply(r, y, f);
            checks++; if (g_lk !== exp_g[0]) begin errors++; $display("FAIL rand_grant cyc=%0d req=%h got=%h exp=%h", i, r, g_lk, exp_g[0]); end
            checks++; if (id_lk !== exp_id[0]) begin errors++; $display("FAIL rand_id cyc=%0d got=%0d exp=%0d", i, id_lk, exp_id[0]); end
            checks++; if (vld_lk !== (exp_p[0] >= 0)) begin errors++; $display("FAIL rand_vld cyc=%0d got=%b", i, vld_lk); end
            checks++; if (g_nl !== exp_g[1]) begin errors++; $display("FAIL rand_grant_nl cyc=%0d req=%h got=%h exp=%h", i, r, g_nl, exp_g[1]); end
            checks++; if (id_nl !== exp_id[1]) begin errors++; $display("FAIL rand_id_nl cyc=%0d got=%0d exp=%0d", i, id_nl, exp_id[1]); end
            checks++; if (vld_nl !== (exp_p[1] >= 0)) begin errors++; $display("FAIL rand_vld_nl cyc=%0d got=%b", i, vld_nl); end
            checks++; if (g_one !== r[0:0] || id_one !== 1'b0 || vld_one !== r[0]) begin
                errors++; $display("FAIL rand_one cyc=%0d got=%b/%b exp=%b/0", i, g_one, id_one, r[0]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_alternate();
        test_lock_hold();
        test_holder_drop();
        test_flush();
        test_async_reset();
        test_nolock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
